seq_magnitude_cmp: RTL
======================

// Module: seq_magnitude_cmp
//
// PURPOSE
//   Parametrised, bit-serial (MSB-first) magnitude comparator.
//   Produces registered gt/eq/lt flags.
//   Supports unsigned and two's-complement signed operands, with a start/done handshake.
//   Exits early at the first differing bit.
//   Successor to the fixed 4-bit combinational greater-than block.
//   Used where wide operands make a flat comparator too costly, and a few cycles of latency are acceptable.
//
// PARAMETERS
//   W       8   operand width in bits; legal range W >= 2
//   SIGNED  0   0 = unsigned compare, 1 = two's-complement signed compare
//
// PORTS
//   clk        in   1  clock; all state changes on the rising edge
//   reset_n    in   1  asynchronous, active-low reset
//   start      in   1  request a compare; sampled only when ready=1
//   a          in   W  operand A; sampled on the edge that accepts start
//   b          in   W  operand B; sampled on the edge that accepts start
//   ready      out  1  1 when idle and able to accept start
//   done_tick  out  1  one-cycle pulse: the result flags are valid
//   gt         out  1  A > B
//   eq         out  1  A == B
//   lt         out  1  A < B
//
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous)
//     - state=IDLE, ready=1, done_tick=0, gt=eq=lt=0.
//     - Operand registers and bit counter cleared.
//     - Applies immediately, including in the middle of a compare; that compare is lost.
//
//   State: IDLE
//     - ready=1.
//     - start=1 at edge k:
//       - latch a and b into shift registers;
//       - bit index := W-1;
//       - gt=eq=lt := 0;
//       - state := CMP.
//     - start=0: remain in IDLE; flags hold their last result.
//
//   State: CMP
//     - ready=0. Each edge examines bit i of the latched operands.
//     - If a[i] != b[i], go to DONE with:
//       - i == W-1 and SIGNED=1: gt = b[i], lt = a[i] (sign bit inverted);
//       - otherwise: gt = a[i], lt = b[i];
//       - eq = 0.
//     - Else if i == 0: go to DONE with eq=1, gt=lt=0.
//     - Else: i := i-1, stay in CMP.
//     - start is ignored; a and b may change freely without effect.
//
//   State: DONE
//     - done_tick=1 for exactly this one cycle, ready=0.
//     - Next edge returns to IDLE.
//     - Flags hold until the next start is accepted.
//
//   Latency
//     - start accepted at edge k; done_tick is high in the cycle after edge k+1+j.
//     - j = number of equal leading MSBs (0..W-1).
//     - Minimum 2 edges (MSBs differ); maximum W+1 edges (operands equal).
//     - start may be raised in the DONE cycle but is not accepted until IDLE.
//     - Back-to-back throughput: one compare per (latency+1) cycles.
//
//   Invariants
//     - At most one of gt/eq/lt is 1.
//     - Exactly one of them is 1 whenever done_tick=1.
//     - The bit counter is $clog2(W) bits wide and never wraps below 0.
//
// TESTING
//   1. W=4, SIGNED=0, exhaustive 256 (a,b) pairs -> gt/eq/lt match a>b, a==b, a<b at every done_tick.
//   2. W=4, SIGNED=1, exhaustive -> a=4'b1000 (-8), b=4'b0111 (7) gives lt=1; a=4'b1111, b=4'b1110 gives gt=1.
//   3. Latency, W=8:
//      - a=8'h80, b=8'h00 -> done_tick 2 edges after acceptance;
//      - a=b=8'hA5 -> W+1=9 edges, eq=1.
//   4. start held high continuously, and new a/b driven during CMP -> only the operands latched at acceptance are used; ready=0 until IDLE.
//   5. reset_n pulsed low mid-CMP (W=8, a=8'hFF, b=8'hFF, after 3 edges) -> immediately ready=1, flags=000, no done_tick; the next compare is correct.
//   6. Default W=8 with W=16 instance: random 10k pairs per mode against a behavioural > / == / < model; check the one-hot flag invariant.

Source files
------------

// File: rtl/seq_magnitude_cmp.sv
// seq_magnitude_cmp: bit-serial, MSB-first magnitude comparator.
// Operands are latched when start is accepted and then shifted left, one bit
// per clock. The compare stops at the first differing bit. The gt/eq/lt flags
// and the handshake outputs are all registered.
module seq_magnitude_cmp #(
   parameter int W      = 8,
   parameter int SIGNED = 0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         ready,
   output logic         done_tick,
   output logic         gt,
   output logic         eq,
   output logic         lt
);

   localparam int            CW      = $clog2(W);
   localparam logic [CW-1:0] IDX_MSB = CW'(W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [W-1:0]  a_r;
   logic [W-1:0]  b_r;
   logic [W-1:0]  a_s;
   logic [W-1:0]  b_s;
   logic [CW-1:0] idx_r;
   logic [CW-1:0] idx_s;
   logic          gt_s;
   logic          eq_s;
   logic          lt_s;
   logic          sign_pos_s;
   logic          msb_a_s;
   logic          msb_b_s;

   // Next-state, operand shift and flag logic of the compare sequencer.
   always_comb begin
      state_s    = state_r;
      a_s        = a_r;
      b_s        = b_r;
      idx_s      = idx_r;
      gt_s       = gt;
      eq_s       = eq;
      lt_s       = lt;
      msb_a_s    = a_r[W-1];
      msb_b_s    = b_r[W-1];
      // The first bit examined is the sign bit in signed mode; a set sign
      // bit means the smaller operand, so its sense is inverted there.
      sign_pos_s = (SIGNED != 0) && (idx_r == IDX_MSB);

      case (state_r)
         S_IDLE: begin
            if (start) begin
               a_s     = a;
               b_s     = b;
               idx_s   = IDX_MSB;
               gt_s    = 1'b0;
               eq_s    = 1'b0;
               lt_s    = 1'b0;
               state_s = S_CMP;
            end else begin
               state_s = S_IDLE;
            end
         end

         S_CMP: begin
            if (msb_a_s != msb_b_s) begin
               state_s = S_DONE;
               eq_s    = 1'b0;
               if (sign_pos_s) begin
                  gt_s = msb_b_s;
                  lt_s = msb_a_s;
               end else begin
                  gt_s = msb_a_s;
                  lt_s = msb_b_s;
               end
            end else if (idx_r == {CW{1'b0}}) begin
               // All bits equal; the counter stops here instead of wrapping.
               state_s = S_DONE;
               gt_s    = 1'b0;
               eq_s    = 1'b1;
               lt_s    = 1'b0;
            end else begin
               idx_s   = idx_r - CW'(1);
               a_s     = {a_r[W-2:0], 1'b0};
               b_s     = {b_r[W-2:0], 1'b0};
               state_s = S_CMP;
            end
         end

         S_DONE: begin
            state_s = S_IDLE;
         end

         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State, operand and flag registers; ready and done_tick follow the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= S_IDLE;
         a_r       <= {W{1'b0}};
         b_r       <= {W{1'b0}};
         idx_r     <= {CW{1'b0}};
         gt        <= 1'b0;
         eq        <= 1'b0;
         lt        <= 1'b0;
         ready     <= 1'b1;
         done_tick <= 1'b0;
      end else begin
         state_r   <= state_s;
         a_r       <= a_s;
         b_r       <= b_s;
         idx_r     <= idx_s;
         gt        <= gt_s;
         eq        <= eq_s;
         lt        <= lt_s;
         ready     <= (state_s == S_IDLE);
         done_tick <= (state_s == S_DONE);
      end
   end

endmodule
